// File: rtl/fwft_64x512_afull.sv
// fwft_64x512_afull: single-clock first-word-fall-through FIFO with a synchronous-read RAM,
// an output register, and programmable almost-full.
module fwft_64x512_afull #(
    parameter int DATA_W           = 64,
    parameter int DEPTH            = 512,
    parameter int PROG_FULL_THRESH = 480
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              full,
    output logic              prog_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, mem_cnt;
    logic              wr, pop, load;

    // count includes the output register; mem_cnt is what still sits in the RAM
    always_comb begin
        wr      = wr_en & ~full & ~srst;
        pop     = rd_en & valid;
        mem_cnt = count - CW'(valid);
        load    = (mem_cnt != '0) & (~valid | pop);
    end

    assign full      = count == CW'(DEPTH);
    assign prog_full = count >= CW'(PROG_FULL_THRESH);
    assign empty     = ~valid;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            valid <= load | (valid & ~pop);
            count <= count + CW'(wr) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fwft_64x512_afull.sv
// tb_fwft_64x512_afull: randomized and directed checks of the FWFT FIFO against a queue model.
module tb_fwft_64x512_afull;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int THR   = 480;
  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          full, prog_full, empty, valid;
  logic [DW-1:0] dout;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [DW-1:0] d;
    int            we;
  } ent_t;
  ent_t q[$];
  int   edge_n   = 0;
  int   last_pop = -10;

  fwft_64x512_afull #(.DATA_W(DW), .DEPTH(DEPTH), .PROG_FULL_THRESH(THR)) dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .full(full),
    .prog_full(prog_full), .rd_en(rd_en), .dout(dout), .empty(empty), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    logic pop, acc;
    wr_en = w;
    rd_en = r;
    din   = d;
    pop   = r && valid && !srst;
    acc   = w && (q.size() < DEPTH) && !srst;
    @(posedge clk);
    edge_n++;
    if (pop && q.size() > 0) begin
      void'(q.pop_front());
      last_pop = edge_n;
    end
    if (acc) q.push_back('{d, edge_n});
    @(negedge clk);
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    srst  = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || prog_full !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b empty=%b full=%b pf=%b dout=%h, need 0 1 0 0 0",
               valid, empty, full, prog_full, dout);
    end
    srst = 1'b0;
    q.delete();
  endtask

  task automatic test_single();
    logic [DW-1:0] w = 64'h0100_0000_0000_0000;
    cycle(1'b1, 1'b0, w);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early: valid=%b need 0", valid);
    end
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (valid !== 1'b1 || dout !== w) begin
      errors++;
      $display("FAIL single_latency: valid=%b dout=%h need 1 %h", valid, dout, w);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (valid !== 1'b1 || dout !== w) begin
        errors++;
        $display("FAIL single_hold[%0d]: valid=%b dout=%h need 1 %h", i, valid, dout, w);
      end
    end
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: valid=%b empty=%b need 0 1", valid, empty);
    end
  endtask

  task automatic test_fill();
    int exp_d = 0;
    int n = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      checks++;
      if (prog_full !== (q.size() >= THR) || full !== (q.size() == DEPTH)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: pf=%b full=%b need %b %b", i, prog_full, full,
                 q.size() >= THR, q.size() == DEPTH);
      end
    end
    checks++;
    if (q.size() != DEPTH || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_drop: full=%b need 1 (model size %0d)", full, q.size());
    end
    while (exp_d < DEPTH && n < 2 * DEPTH) begin
      if (valid) begin
        checks++;
        if (dout !== DW'(exp_d)) begin
          errors++;
          $display("FAIL fill_order: dout=%0d need %0d", dout, exp_d);
        end
        exp_d++;
      end
      cycle(1'b0, 1'b1, '0);
      checks++;
      if (prog_full !== (q.size() >= THR) || full !== (q.size() == DEPTH)) begin
        errors++;
        $display("FAIL drain_flags: pf=%b full=%b need %b %b", prog_full, full, q.size() >= THR, q.size() == DEPTH);
      end
      n++;
    end
    checks++;
    if (exp_d != DEPTH || empty !== 1'b1) begin
      errors++;
      $display("FAIL fill_drain_end: popped=%0d empty=%b need %0d 1", exp_d, empty, DEPTH);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, '0);
      checks++;
      if (valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || prog_full !== 1'b0) begin
        errors++;
        $display("FAIL underflow[%0d]: valid=%b empty=%b full=%b pf=%b need 0 1 0 0", i, valid, empty, full, prog_full);
      end
    end
    cycle(1'b1, 1'b0, 64'hA5A5);
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (valid !== 1'b1 || dout !== 64'hA5A5) begin
      errors++;
      $display("FAIL underflow_recover: valid=%b dout=%h need 1 a5a5", valid, dout);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, {$urandom, $urandom});
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (full !== 1'b1 || valid !== 1'b1 || dout !== q[0].d) begin
      errors++;
      $display("FAIL overflow_full: full=%b valid=%b dout=%h need 1 1 %h", full, valid, dout, q[0].d);
    end
    cycle(1'b1, 1'b1, 64'hDEAD_BEEF);
    checks++;
    if (q.size() != DEPTH - 1 || full !== 1'b0 || prog_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_both: full=%b pf=%b need 0 1 (model size %0d need 511)", full, prog_full, q.size());
    end
    checks++;
    if (valid !== 1'b1 || dout !== q[0].d) begin
      errors++;
      $display("FAIL overflow_next: valid=%b dout=%h need 1 %h", valid, dout, q[0].d);
    end
    cycle(1'b1, 1'b0, 64'h1234);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_refill: full=%b need 1", full);
    end
  endtask

  task automatic test_reset_midop();
    logic [DW-1:0] w = 64'hCAFE_F00D_0000_0001;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(i + 7));
    cycle(1'b0, 1'b0, '0);
    #2 srst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || prog_full !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_async: valid=%b empty=%b full=%b pf=%b dout=%h need 0 1 0 0 0",
               valid, empty, full, prog_full, dout);
    end
    @(negedge clk);
    cycle(1'b1, 1'b1, 64'h77);
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_write: valid=%b need 0", valid);
    end
    srst = 1'b0;
    q.delete();
    cycle(1'b1, 1'b0, w);
    cycle(1'b0, 1'b0, '0);
    checks++;
    if (valid !== 1'b1 || dout !== w) begin
      errors++;
      $display("FAIL reset_first_write: valid=%b dout=%h need 1 %h", valid, dout, w);
    end
    cycle(1'b0, 1'b1, '0);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: valid=%b need 0 (old words must be gone)", valid);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp_d;
    int n = 0;
    do_reset();
    for (int c = 0; c < 1000 + 2 * DEPTH; c++) begin
      if (c < 1000) cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20, {$urandom, $urandom});
      else if (q.size() > 0) cycle(1'b0, 1'b1, '0);
      else break;
      checks++;
      if (full !== (q.size() == DEPTH) || prog_full !== (q.size() >= THR) || empty !== ~valid) begin
        errors++;
        $display("FAIL stream_flags@%0d: full=%b pf=%b empty=%b valid=%b size=%0d", c, full, prog_full, empty, valid, q.size());
      end
      if (valid) begin
        exp_d = (q.size() > 0) ? q[0].d : '0;
        checks++;
        if (q.size() == 0 || dout !== exp_d) begin
          errors++;
          $display("FAIL stream_data@%0d: dout=%h need %h (size %0d)", c, dout, exp_d, q.size());
        end
        n++;
      end
      if (q.size() > 0 && q[0].we <= edge_n - 1 && last_pop != edge_n) begin
        checks++;
        if (valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_fwft@%0d: valid=%b need 1", c, valid);
        end
      end
    end
    checks++;
    if (q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b need 0 (model size %0d)", valid, q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_underflow();
    test_overflow();
    test_reset_midop();
    test_streaming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwft_64x512_afull.md
FWFT_64X512_AFULL -- requirements
Module: fwft_64x512_afull

Interface
REQ-001 Parameter DATA_W, default 64, data width in bits.
REQ-002 Parameter DEPTH, default 512, total word capacity; power of two.
REQ-003 Parameter PROG_FULL_THRESH, default 480, occupancy at which prog_full asserts.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 srst  input  1  reset; asynchronous, active-high (name kept per codebase).
REQ-006 din  input  DATA_W  write data.
REQ-007 wr_en  input  1  write request.
REQ-008 full  output  1  occupancy == DEPTH.
REQ-009 prog_full  output  1  occupancy >= PROG_FULL_THRESH.
REQ-010 rd_en  input  1  read/acknowledge of the word currently on dout.
REQ-011 dout  output  DATA_W  head-of-queue word (first-word-fall-through).
REQ-012 empty  output  1  no word presented on dout; always equals ~valid.
REQ-013 valid  output  1  dout holds a valid head word.

Function
REQ-014 The block SHALL be a synchronous single-clock FIFO: DEPTH-entry storage (synchronous-read RAM) plus one output register; occupancy counts all stored words including the output register, range 0..DEPTH.
REQ-015 The block SHALL accept a write on an edge where wr_en=1 and full=0; wr_en=1 with full=1 SHALL be ignored (word dropped, no state change, no error flag).
REQ-016 The block SHALL pop the head on an edge where rd_en=1 and valid=1; rd_en=1 with valid=0 SHALL be ignored (no underflow).
REQ-017 The block SHALL present the head word on dout with valid=1 without any rd_en request (FWFT); dout SHALL remain stable while valid=1 and no pop occurs.
REQ-018 Write-to-valid latency into an empty FIFO SHALL be 2 rising edges: word sampled at edge k, valid=1 and dout=word after edge k+1.
REQ-019 After a pop at edge k with further words stored, the next word SHALL appear on dout after edge k or k+1; back-to-back pops with rd_en held high SHALL sustain one word per cycle once the pipeline is primed.
REQ-020 Words SHALL be delivered in write order, bit-exact, none lost or duplicated.
REQ-021 Simultaneous accepted write and pop SHALL leave occupancy unchanged; full/prog_full SHALL be evaluated from pre-edge state, so a write when full=1 is dropped even if a pop occurs on the same edge.
REQ-022 Occupancy SHALL update: +1 on write only, -1 on pop only, unchanged on both or neither.
REQ-023 full and prog_full SHALL be registered (or decoded from the registered occupancy), glitch-free, updating on the same edge as occupancy.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH with no lost slot.

Reset
REQ-025 srst=1 SHALL asynchronously force occupancy=0, pointers=0, valid=0, empty=1, full=0, prog_full=0, dout=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; wr_en/rd_en while srst=1 SHALL be ignored.
REQ-027 After srst deasserts, the first rising edge SHALL accept a write normally.

Verification
REQ-028 Reset: srst pulse with FIFO holding data -> valid=0, empty=1, full=0, prog_full=0, dout=0 immediately (before next edge).
REQ-029 Single word: write din=0x0100_0000_0000_0000 at edge k, rd_en=0 -> valid=1, dout=that value after edge k+1, held for 20 cycles; rd_en=1 one cycle -> valid=0.
REQ-030 Fill: 513 writes of 0..512, rd_en=0 -> prog_full rises after 480th write, full after 512th, word 512 dropped; then rd_en=1 -> dout sequence 0..511 exactly, then empty=1, full/prog_full clear on the crossing edges.
REQ-031 Streaming: random wr_en (~20% duty) and random rd_en (~20% duty) for 1000 cycles -> scoreboard matches order and content, occupancy never exceeds DEPTH.
REQ-032 Underflow/overflow: rd_en=1 while empty for 10 cycles -> no state change; wr_en and rd_en both high while full -> write dropped, one word popped, occupancy 511.
